// File: rtl/router_reg.sv
// Router datapath register stage: header capture, full-FIFO byte buffering,
// XOR parity accumulation/check and payload length check, driven by FSM strobes.
module router_reg #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          pkt_valid,
  input  logic [DW-1:0] data_in,
  input  logic          fifo_full,
  input  logic          detect_add,
  input  logic          lfd_state,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          full_state,
  input  logic          rst_int_reg,
  output logic          parity_done,
  output logic          low_pkt_valid,
  output logic          err,
  output logic          len_err,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] hdr_q, hdr_d;
  logic [DW-1:0] holdByte_q, holdByte_d;
  logic [DW-1:0] intPar_q, intPar_d;
  logic [DW-1:0] pktPar_q, pktPar_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-3:0] lenCnt_q, lenCnt_d;
  logic          lowPktValid_q, lowPktValid_d;
  logic          parityDone_q, parityDone_d;
  logic          err_q, err_d;
  logic          lenErr_q, lenErr_d;

  localparam logic [DW-3:0] LenOne = {{(DW-3){1'b0}}, 1'b1};

  // full_state needs no term of its own: every register simply holds there
  always_comb begin
    hdr_d         = hdr_q;
    dout_d        = dout_q;
    holdByte_d    = holdByte_q;
    intPar_d      = intPar_q;
    pktPar_d      = pktPar_q;
    lenCnt_d      = lenCnt_q;
    lowPktValid_d = lowPktValid_q;
    parityDone_d  = parityDone_q;
    err_d         = err_q;
    lenErr_d      = lenErr_q;

    if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) hdr_d = data_in;

    if (lfd_state)                    dout_d = hdr_q;
    else if (ld_state && !fifo_full)  dout_d = data_in;
    else if (laf_state)               dout_d = holdByte_q;

    if (ld_state && fifo_full) holdByte_d = data_in;

    if (lfd_state) begin
      intPar_d = hdr_q;
      pktPar_d = '0;
      lenCnt_d = '0;
    end else if (ld_state) begin
      if (pkt_valid) begin
        intPar_d = intPar_q ^ data_in;
        lenCnt_d = lenCnt_q + LenOne;
      end else begin
        pktPar_d = data_in;
      end
    end

    if (rst_int_reg)                   lowPktValid_d = 1'b0;
    else if (ld_state && !pkt_valid)   lowPktValid_d = 1'b1;

    // parity_done survives DECODE so the FSM can still see it after LOAD_AFTER_FULL
    if (lfd_state)
      parityDone_d = 1'b0;
    else if ((ld_state && !fifo_full && !pkt_valid) ||
             (laf_state && lowPktValid_q && !parityDone_q))
      parityDone_d = 1'b1;

    if (lfd_state) begin
      err_d    = 1'b0;
      lenErr_d = 1'b0;
    end else if (rst_int_reg) begin
      err_d    = (intPar_q != pktPar_q);
      lenErr_d = (lenCnt_q != hdr_q[DW-1:2]);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hdr_q         <= '0;
      dout_q        <= '0;
      holdByte_q    <= '0;
      intPar_q      <= '0;
      pktPar_q      <= '0;
      lenCnt_q      <= '0;
      lowPktValid_q <= 1'b0;
      parityDone_q  <= 1'b0;
      err_q         <= 1'b0;
      lenErr_q      <= 1'b0;
    end else begin
      hdr_q         <= hdr_d;
      dout_q        <= dout_d;
      holdByte_q    <= holdByte_d;
      intPar_q      <= intPar_d;
      pktPar_q      <= pktPar_d;
      lenCnt_q      <= lenCnt_d;
      lowPktValid_q <= lowPktValid_d;
      parityDone_q  <= parityDone_d;
      err_q         <= err_d;
      lenErr_q      <= lenErr_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parityDone_q;
  assign low_pkt_valid = lowPktValid_q;
  assign err           = err_q;
  assign len_err       = lenErr_q;

endmodule

// File: tb/tb_router_reg.sv
// Scoreboard bench for router_reg: a driver emulates the router FSM strobes and queues
// expected FIFO bytes; a monitor checks dout whenever a FIFO write would occur.
module tb_router_reg;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;
  logic       len_err;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbq[$];
  logic [7:0] txBytes[$];
  logic [7:0] curHdr;
  logic [7:0] lastOut;
  logic       expErr;
  logic       expLenErr;
  logic       expPdone;

  router_reg #(.DW(8)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err),
    .len_err      (len_err),
    .dout         (dout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearIns();
    pkt_valid   = 1'b0;
    data_in     = 8'h00;
    fifo_full   = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_dout"}, dout, 8'h00);
    checkOutput({tag, "_pdone"}, {7'd0, parity_done}, 8'h00);
    checkOutput({tag, "_lowpv"}, {7'd0, low_pkt_valid}, 8'h00);
    checkOutput({tag, "_err"}, {7'd0, err}, 8'h00);
    checkOutput({tag, "_lenerr"}, {7'd0, len_err}, 8'h00);
  endtask

  // Monitor: a FIFO write happens on the edge where lfd, unblocked ld, or laf is seen
  initial begin
    logic wrSeen;
    logic [7:0] expByte;
    forever begin
      @(posedge clock);
      wrSeen = resetn && (lfd_state || (ld_state && !fifo_full) || laf_state);
      @(negedge clock);
      if (wrSeen) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("[TB] FAIL dout_unexpected: got %h expected no write", dout);
        end else begin
          expByte = sbq.pop_front();
          if (dout !== expByte) begin
            errors++;
            $display("[TB] FAIL dout_seq: got %h expected %h", dout, expByte);
          end
        end
      end
    end
  end

  // One packet through DECODE, LFD, LD (optionally stalled), parity, CHECK_PARITY
  task automatic applyStimulus(input logic [7:0] hdr, input logic [7:0] par,
                               input int fullAt, input bit parFull, input int abortAt);
    logic [7:0] ip;
    logic [5:0] cnt;
    int n;
    n = txBytes.size();

    clearIns(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
    tick();
    if (hdr[1:0] != 2'b11) curHdr = hdr;
    checkOutput("dec_err_held", {7'd0, err}, {7'd0, expErr});
    checkOutput("dec_lenerr_held", {7'd0, len_err}, {7'd0, expLenErr});
    checkOutput("dec_pdone_held", {7'd0, parity_done}, {7'd0, expPdone});

    clearIns(); lfd_state = 1'b1; pkt_valid = 1'b1;
    sbq.push_back(curHdr); lastOut = curHdr;
    tick();
    checkOutput("lfd_err_clr", {7'd0, err}, 8'h00);
    checkOutput("lfd_pdone_clr", {7'd0, parity_done}, 8'h00);

    ip = curHdr;
    cnt = 6'd0;
    for (int i = 0; i < n; i++) begin
      if (i == abortAt) begin
        clearIns(); resetn = 1'b0;
        tick();
        resetChecks("midreset");
        resetn = 1'b1;
        curHdr = 8'h00; lastOut = 8'h00;
        expErr = 1'b0; expLenErr = 1'b0; expPdone = 1'b0;
        return;
      end
      clearIns(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = txBytes[i];
      ip = ip ^ txBytes[i];
      cnt = cnt + 6'd1;
      if (i == fullAt) begin
        fifo_full = 1'b1;
        tick();
        clearIns(); full_state = 1'b1; fifo_full = 1'b1; pkt_valid = 1'b1; data_in = 8'hA5;
        tick();
        checkOutput("full_dout_hold", dout, lastOut);
        clearIns(); laf_state = 1'b1; pkt_valid = 1'b1; data_in = 8'hA5;
        sbq.push_back(txBytes[i]); lastOut = txBytes[i];
        tick();
        checkOutput("laf_pdone_low", {7'd0, parity_done}, 8'h00);
      end else begin
        sbq.push_back(txBytes[i]); lastOut = txBytes[i];
        tick();
      end
    end

    clearIns(); ld_state = 1'b1; data_in = par;
    if (parFull) begin
      fifo_full = 1'b1;
      tick();
      checkOutput("parfull_lowpv", {7'd0, low_pkt_valid}, 8'h01);
      checkOutput("parfull_pdone", {7'd0, parity_done}, 8'h00);
      clearIns(); full_state = 1'b1; fifo_full = 1'b1;
      tick();
      checkOutput("parfull_dout_hold", dout, lastOut);
      clearIns(); laf_state = 1'b1;
      sbq.push_back(par); lastOut = par;
      tick();
      checkOutput("laf_pdone_set", {7'd0, parity_done}, 8'h01);
    end else begin
      sbq.push_back(par); lastOut = par;
      tick();
      checkOutput("par_pdone", {7'd0, parity_done}, 8'h01);
      checkOutput("par_lowpv", {7'd0, low_pkt_valid}, 8'h01);
    end

    clearIns();
    tick();
    clearIns(); rst_int_reg = 1'b1;
    tick();
    clearIns();
    expErr = (ip != par);
    expLenErr = (cnt != curHdr[7:2]);
    expPdone = 1'b1;
    checkOutput("chk_lowpv_clr", {7'd0, low_pkt_valid}, 8'h00);
    checkOutput("chk_err", {7'd0, err}, {7'd0, expErr});
    checkOutput("chk_lenerr", {7'd0, len_err}, {7'd0, expLenErr});
  endtask

  initial begin
    logic [7:0] wrapPar;
    clearIns();
    resetn = 1'b0;
    curHdr = 8'h00; lastOut = 8'h00;
    expErr = 1'b0; expLenErr = 1'b0; expPdone = 1'b0;
    tick();
    tick();
    resetChecks("reset");
    resetn = 1'b1;

    // Clean packet; then bad parity; then payload stall; then parity stall
    txBytes = '{8'h11, 8'h22, 8'h33};
    applyStimulus(8'h0D, 8'h0D, -1, 1'b0, -1);
    applyStimulus(8'h0D, 8'hFF, -1, 1'b0, -1);
    applyStimulus(8'h0D, 8'h0D, 1, 1'b0, -1);
    applyStimulus(8'h0D, 8'h0D, -1, 1'b1, -1);

    // Short packet: header says 4 bytes, only 3 sent
    applyStimulus(8'h11, 8'h11, -1, 1'b0, -1);

    // Address 3 header is ignored: previous header 8'h11 (len 4) is reused
    txBytes = '{8'h01, 8'h02, 8'h04, 8'h08};
    applyStimulus(8'h0F, 8'h1E, -1, 1'b0, -1);

    // 64 payload bytes wrap the 6-bit counter back to 0 == header length 0
    txBytes.delete();
    wrapPar = 8'h00;
    for (int i = 0; i < 64; i++) begin
      txBytes.push_back(8'(i * 3 + 1));
      wrapPar = wrapPar ^ 8'(i * 3 + 1);
    end
    applyStimulus(8'h00, wrapPar, -1, 1'b0, -1);

    // Reset mid-payload, then a clean packet
    txBytes = '{8'h11, 8'h22, 8'h33};
    applyStimulus(8'h0D, 8'h0D, -1, 1'b0, 2);
    applyStimulus(8'h0D, 8'h0D, -1, 1'b0, -1);

    tick();
    tick();
    checkOutput("sb_empty", 8'(sbq.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
